mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, number of extra backing-memory wait cycles per access (legal range 0..15).
REQ-002 SHALL have ports, clock and reset first:
  clock  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-low reset
  req_read  in  1  load request from controller
  req_write  in  1  store request from controller
  req_addr  in  32  byte address
  req_wrbits  in  4  store byte-lane mask
  req_funct3  in  3  ir[14:12] of the current instruction
  req_wdata  in  32  store data, B register, unaligned
  busy  out  1  access in progress
  done  out  1  one-cycle completion pulse
  rdata  out  32  aligned and extended load data
  sram_cs  out  1  backing-memory select
  sram_we  out  1  backing-memory write enable
  sram_be  out  4  backing-memory byte enables
  sram_addr  out  30  word address, req_addr[31:2]
  sram_wdata  out  32  lane-replicated store data
  sram_rdata  in  32  backing-memory read word
  err  out  1  misaligned-access pulse (MEMRESP_ALIGN_CHK_EN only)

Function
REQ-003 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE.
REQ-004 In IDLE, req_read or req_write high SHALL capture addr, wrbits, funct3 and wdata, then enter ACCESS next cycle.
REQ-005 If req_read and req_write are both high, the access SHALL be treated as a write.
REQ-006 Requests outside IDLE SHALL be ignored, with no queuing.
REQ-007 ACCESS SHALL last exactly WAIT_CYCLES+1 cycles, timed by a 4-bit down-counter.
REQ-008 Throughout ACCESS: sram_cs=1 and sram_we=(write), all SRAM outputs driven from captured registers.
REQ-009 On the last ACCESS cycle edge, reads SHALL register sram_rdata-derived data into rdata.
REQ-010 RESP SHALL last one cycle with done=1, returning to IDLE.
REQ-011 Latency SHALL be: request sampled at edge N gives done high during cycle N+WAIT_CYCLES+2.
REQ-012 busy SHALL be 1 in ACCESS and RESP, 0 in IDLE.
REQ-013 Store lanes: funct3 000 gives sram_wdata={4{wdata[7:0]}}; 001 gives {2{wdata[15:0]}}; otherwise wdata.
REQ-014 sram_be SHALL equal the captured wrbits for writes and 4'b0000 for reads.
REQ-015 Load extraction:
  000 LB: byte at addr[1:0], sign-extended.
  100 LBU: byte at addr[1:0], zero-extended.
  001 LH: half at addr[1], sign-extended.
  101 LHU: half at addr[1], zero-extended.
  010 and all others: full word.
REQ-016 rdata SHALL hold its value until the next completed read; writes leave it unchanged.
REQ-017 When not in ACCESS, sram_cs, sram_we and sram_be SHALL be 0.

Reset
REQ-018 reset low SHALL force IDLE, counter 0, and busy, done, err, rdata, sram_cs, sram_we, sram_be, sram_addr, sram_wdata all 0, independent of clock.
REQ-019 reset asserted mid-ACCESS SHALL abort the access (sram_cs/sram_we drop immediately), with no done and no err afterwards.

Configuration
REQ-020 With MEMRESP_ALIGN_CHK_EN defined, misaligned requests (funct3 001/101 with addr[0]=1; funct3 010 with addr[1:0]!=0) SHALL skip ACCESS, go directly to RESP, and pulse err and done together.
REQ-021 On a misaligned request, sram_cs SHALL stay 0 and rdata SHALL be unchanged.
REQ-022 Without MEMRESP_ALIGN_CHK_EN, err SHALL be tied 0, address low bits SHALL be used as-is, and misaligned halfwords SHALL read bytes addr[1]-selected.

Structure
REQ-023 A shared package kappa3_pkg SHALL hold the FSM state encoding and the funct3 load/store constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
REQ-024 Load alignment/extension SHALL be a sub-module load_align (combinational: word, addr[1:0], funct3 -> 32-bit).

Verification
REQ-025 WAIT_CYCLES=1, read addr 0x104, funct3 010, sram_rdata 0xDEADBEEF -> sram_addr 0x41, sram_cs high 2 cycles, done on 3rd cycle after request, rdata 0xDEADBEEF.
REQ-026 LB addr 0x203, sram_rdata 0x80112233 -> rdata 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x202 -> 0x00008011.
REQ-027 SB addr 0x1, wdata 0x000000A5, wrbits 0010 -> sram_wdata 0xA5A5A5A5, sram_be 0010, sram_we high WAIT_CYCLES+1 cycles.
REQ-028 New request during busy -> ignored; simultaneous read+write -> sram_we=1.
REQ-029 reset low in the 1st ACCESS cycle -> sram_cs=0 immediately, no done ever; WAIT_CYCLES=0 -> done 2 cycles after request.
REQ-030 With MEMRESP_ALIGN_CHK_EN, LW addr 0x102 -> err and done pulse together one cycle after request, sram_cs never high.

Source files
------------

// File: rtl/kappa3_pkg.sv
// Shared types and funct3 constants for the kappa3 memory responder.
// Used by mem_responder and load_align.
package kappa3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic [31:0] store_lanes(
    input logic [2:0]  f3,
    input logic [31:0] wd
  );
    case (f3)
      F3_SB:   return {4{wd[7:0]}};
      F3_SH:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    case (f3)
      F3_LH, F3_LHU: return lo[0];
      F3_LW:         return lo != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_responder_load_align.sv
// load_align: picks the addressed byte/half out of a memory
// word and sign- or zero-extends it according to funct3.
module load_align
  import kappa3_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   data = {{24{b[7]}}, b};
      F3_LBU:  data = {24'b0, b};
      F3_LH:   data = {{16{h[15]}}, h};
      F3_LHU:  data = {16'b0, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding load/store front end to a waited SRAM.
// Optional MEMRESP_ALIGN_CHK_EN rejects misaligned accesses with err.
module mem_responder
  import kappa3_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_wrbits,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        sram_cs,
  output logic        sram_we,
  output logic [3:0]  sram_be,
  output logic [29:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic        err
);

  localparam logic [3:0] WAIT4 = 4'(WAIT_CYCLES);

  state_e      state;
  logic [3:0]  cnt;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic        write_q;
  logic [31:0] ld_data;

  load_align u_align (
    .word    (sram_rdata),
    .addr_lo (addr_lo_q),
    .funct3  (funct3_q),
    .data    (ld_data)
  );

`ifdef MEMRESP_ALIGN_CHK_EN
  logic err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      funct3_q   <= 3'd0;
      addr_lo_q  <= 2'd0;
      write_q    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rdata      <= 32'd0;
      sram_cs    <= 1'b0;
      sram_we    <= 1'b0;
      sram_be    <= 4'd0;
      sram_addr  <= 30'd0;
      sram_wdata <= 32'd0;
`ifdef MEMRESP_ALIGN_CHK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MEMRESP_ALIGN_CHK_EN
      err_q <= 1'b0;
`endif
      unique case (state)
        ST_IDLE: begin
          if (req_read || req_write) begin
            funct3_q   <= req_funct3;
            addr_lo_q  <= req_addr[1:0];
            write_q    <= req_write;
            sram_addr  <= req_addr[31:2];
            sram_wdata <= store_lanes(req_funct3, req_wdata);
            busy       <= 1'b1;
`ifdef MEMRESP_ALIGN_CHK_EN
            if (misaligned(req_funct3, req_addr[1:0])) begin
              state <= ST_RESP;
              done  <= 1'b1;
              err_q <= 1'b1;
            end else
`endif
            begin
              state   <= ST_ACCESS;
              cnt     <= WAIT4;
              sram_cs <= 1'b1;
              sram_we <= req_write;
              sram_be <= req_write ? req_wrbits : 4'd0;
            end
          end
        end
        ST_ACCESS: begin
          if (cnt == 4'd0) begin
            state   <= ST_RESP;
            done    <= 1'b1;
            sram_cs <= 1'b0;
            sram_we <= 1'b0;
            sram_be <= 4'd0;
            if (!write_q) rdata <= ld_data;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (WAIT_CYCLES=1 and 0 instances).
// Align-check vectors apply only when MEMRESP_ALIGN_CHK_EN is defined.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_wrbits = '0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] sram_rdata = '0;

  logic        busy, done, sram_cs, sram_we, err;
  logic [31:0] rdata, sram_wdata;
  logic [3:0]  sram_be;
  logic [29:0] sram_addr;

  logic        busy0, done0, cs0, we0, err0;
  logic [31:0] rdata0, wdata0;
  logic [3:0]  be0;
  logic [29:0] addr0;

  int nvec = 0;
  int nbad = 0;

  int cs_n, we_n, busy_n, done_n, done_at, done0_at, err_n, err_at;
  logic [3:0]  be_seen;
  logic [29:0] addr_seen;
  logic [31:0] wd_seen;

  always #5 clk = ~clk;

  mem_responder #(.WAIT_CYCLES(1)) u_dut (
    .clock(clk), .reset(rst_n),
    .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wrbits(req_wrbits),
    .req_funct3(req_funct3), .req_wdata(req_wdata),
    .busy(busy), .done(done), .rdata(rdata),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_be(sram_be),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .err(err)
  );

  mem_responder #(.WAIT_CYCLES(0)) u_dut0 (
    .clock(clk), .reset(rst_n),
    .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wrbits(req_wrbits),
    .req_funct3(req_funct3), .req_wdata(req_wdata),
    .busy(busy0), .done(done0), .rdata(rdata0),
    .sram_cs(cs0), .sram_we(we0), .sram_be(be0),
    .sram_addr(addr0), .sram_wdata(wdata0),
    .sram_rdata(sram_rdata), .err(err0)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request, then watch 10 cycles; poke fires a stray write in cycle 1
  task automatic run(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [3:0] wb, input logic [2:0] f3,
                     input logic [31:0] wd, input logic poke);
    @(negedge clk);
    req_read = rd; req_write = wr; req_addr = a;
    req_wrbits = wb; req_funct3 = f3; req_wdata = wd;
    @(negedge clk);
    req_read = 1'b0; req_write = 1'b0;
    cs_n = 0; we_n = 0; busy_n = 0; done_n = 0; err_n = 0;
    done_at = -1; done0_at = -1; err_at = -1;
    be_seen = '0; addr_seen = '0; wd_seen = '0;
    for (int c = 1; c <= 10; c++) begin
      if (sram_cs) begin
        cs_n++;
        be_seen = sram_be; addr_seen = sram_addr; wd_seen = sram_wdata;
      end
      if (sram_we) we_n++;
      if (busy) busy_n++;
      if (done) begin done_n++; if (done_at < 0) done_at = c; end
      if (err) begin err_n++; if (err_at < 0) err_at = c; end
      if (done0 && done0_at < 0) done0_at = c;
      if (c == 1 && poke) begin
        req_write = 1'b1; req_addr = 32'h300; req_wrbits = 4'hF;
      end
      if (c == 2) req_write = 1'b0;
      if (c < 10) @(negedge clk);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_cs", 32'(sram_cs), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    sram_rdata = 32'hDEADBEEF;
    run(1, 0, 32'h104, 4'h0, 3'b010, 32'h0, 0);
    chk("lw_addr", 32'(addr_seen), 32'h41);
    chk("lw_cs_cyc", 32'(cs_n), 32'd2);
    chk("lw_we_cyc", 32'(we_n), 32'd0);
    chk("lw_be", 32'(be_seen), 32'd0);
    chk("lw_done_at", 32'(done_at), 32'd3);
    chk("lw_done_n", 32'(done_n), 32'd1);
    chk("lw_busy_cyc", 32'(busy_n), 32'd3);
    chk("lw_rdata", rdata, 32'hDEADBEEF);
    chk("w0_done_at", 32'(done0_at), 32'd2);
    chk("w0_rdata", rdata0, 32'hDEADBEEF);

    sram_rdata = 32'h80112233;
    run(1, 0, 32'h203, 4'h0, 3'b000, 32'h0, 0);
    chk("lb_203", rdata, 32'hFFFFFF80);
    run(1, 0, 32'h203, 4'h0, 3'b100, 32'h0, 0);
    chk("lbu_203", rdata, 32'h00000080);
    run(1, 0, 32'h202, 4'h0, 3'b101, 32'h0, 0);
    chk("lhu_202", rdata, 32'h00008011);
    run(1, 0, 32'h202, 4'h0, 3'b001, 32'h0, 0);
    chk("lh_202", rdata, 32'hFFFF8011);
    run(1, 0, 32'h200, 4'h0, 3'b001, 32'h0, 0);
    chk("lh_200", rdata, 32'h00002233);
    run(1, 0, 32'h201, 4'h0, 3'b000, 32'h0, 0);
    chk("lb_201", rdata, 32'h00000022);

    run(0, 1, 32'h1, 4'b0010, 3'b000, 32'h000000A5, 0);
    chk("sb_wdata", wd_seen, 32'hA5A5A5A5);
    chk("sb_be", 32'(be_seen), 32'b0010);
    chk("sb_we_cyc", 32'(we_n), 32'd2);
    chk("sb_done_at", 32'(done_at), 32'd3);
    chk("sb_rdata_hold", rdata, 32'h00000022);
    run(0, 1, 32'h2, 4'b1100, 3'b001, 32'h1234BEEF, 0);
    chk("sh_wdata", wd_seen, 32'hBEEFBEEF);
    run(0, 1, 32'h10, 4'b1111, 3'b010, 32'h1234BEEF, 0);
    chk("sw_wdata", wd_seen, 32'h1234BEEF);
    chk("sw_addr", 32'(addr_seen), 32'h4);

    sram_rdata = 32'hCAFEF00D;
    run(1, 0, 32'h104, 4'h0, 3'b010, 32'h0, 1);
    chk("busy_ign_we", 32'(we_n), 32'd0);
    chk("busy_ign_cs", 32'(cs_n), 32'd2);
    chk("busy_ign_done", 32'(done_n), 32'd1);
    chk("busy_ign_rdata", rdata, 32'hCAFEF00D);

    run(1, 1, 32'h8, 4'b0011, 3'b010, 32'h55AA55AA, 0);
    chk("rw_we_cyc", 32'(we_n), 32'd2);
    chk("rw_be", 32'(be_seen), 32'b0011);
    chk("rw_rdata_hold", rdata, 32'hCAFEF00D);

    @(negedge clk);
    req_write = 1'b1; req_addr = 32'h40; req_funct3 = 3'b010;
    req_wrbits = 4'hF;
    @(negedge clk);
    req_write = 1'b0;
    chk("mid_cs_before", 32'(sram_cs), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_cs_after", 32'(sram_cs), 32'd0);
    chk("mid_we_after", 32'(sram_we), 32'd0);
    chk("mid_busy_after", 32'(busy), 32'd0);
    chk("mid_rdata_after", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_n = 0; err_n = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || done0) done_n++;
      if (err) err_n++;
    end
    chk("mid_no_done", 32'(done_n), 32'd0);
    chk("mid_no_err", 32'(err_n), 32'd0);

    sram_rdata = 32'h0BADF00D;
`ifdef MEMRESP_ALIGN_CHK_EN
    run(1, 0, 32'h102, 4'h0, 3'b010, 32'h0, 0);
    chk("mis_done_at", 32'(done_at), 32'd1);
    chk("mis_err_at", 32'(err_at), 32'd1);
    chk("mis_err_n", 32'(err_n), 32'd1);
    chk("mis_cs_cyc", 32'(cs_n), 32'd0);
    chk("mis_rdata", rdata, 32'd0);
`else
    run(1, 0, 32'h102, 4'h0, 3'b010, 32'h0, 0);
    chk("noalign_done_at", 32'(done_at), 32'd3);
    chk("noalign_err_n", 32'(err_n), 32'd0);
    chk("noalign_rdata", rdata, 32'h0BADF00D);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
